// File: rtl/barrett_pkg.sv
// rtl/barrett_pkg.sv - shared types and defaults for the Barrett modular multiply sequencer
package barrett_pkg;

    localparam int W_DEF    = 64;
    localparam int KW_DEF   = 8;
    localparam int CORR_MAX = 2;

    typedef enum logic [3:0] {
        IDLE,
        MUL_Z,
        WAIT_Z,
        MUL_M2,
        WAIT_M2,
        MUL_P,
        WAIT_P,
        SUB,
        CORR,
        DONE
    } state_t;

endpackage

// File: rtl/barrett_cfg_regs.sv
// rtl/barrett_cfg_regs.sv - modulus configuration registers with range check and reject pulse
module barrett_cfg_regs
    import barrett_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int KW = KW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic          busy,
    input  logic [W-1:0]  cfg_q,
    input  logic [KW-1:0] cfg_k,
    input  logic [W-1:0]  cfg_mu,
    output logic [W-1:0]  q,
    output logic [KW-1:0] k,
    output logic [W-1:0]  mu,
    output logic          cfg_err
);

    localparam logic [KW-1:0] K_MAX = KW'(W - 1);

    logic k_ok;
    assign k_ok = (cfg_k != '0) && (cfg_k <= K_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= '0;
            k       <= '0;
            mu      <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            if (cfg_we) begin
                if (!busy && k_ok) begin
                    q  <= cfg_q;
                    k  <= cfg_k;
                    mu <= cfg_mu;
                end else begin
                    cfg_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/barrett_modmul_ctrl.sv
// rtl/barrett_modmul_ctrl.sv - Barrett (a*b) mod q sequencer driving one shared external multiplier
module barrett_modmul_ctrl
    import barrett_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int KW = KW_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_we,
    input  logic [W-1:0]   cfg_q,
    input  logic [KW-1:0]  cfg_k,
    input  logic [W-1:0]   cfg_mu,
    output logic           cfg_err,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_t,
    output logic           out_err,
    output logic           busy,
    output logic           mul_start,
    output logic [W-1:0]   mul_a,
    output logic [W-1:0]   mul_b,
    input  logic           mul_done,
    input  logic [2*W-1:0] mul_p
);

    state_t          state;
    logic [W-1:0]    q;
    logic [KW-1:0]   k;
    logic [W-1:0]    mu;
    logic [2*W-1:0]  z;
    logic [2*W-1:0]  p_r;
    logic [W+1:0]    t;
    logic [1:0]      cnt;
    logic [2*W-1:0]  p_shr;
    logic [2*W-1:0]  diff;
    logic [W+1:0]    q_ext;

    barrett_cfg_regs #(.W(W), .KW(KW)) u_cfg (
        .clk     (clk),
        .rst     (rst),
        .cfg_we  (cfg_we),
        .busy    (busy),
        .cfg_q   (cfg_q),
        .cfg_k   (cfg_k),
        .cfg_mu  (cfg_mu),
        .q       (q),
        .k       (k),
        .mu      (mu),
        .cfg_err (cfg_err)
    );

    // Both quotient estimates (m1 from z, m3 from m2) are the product shifted right by k.
    assign p_shr = mul_p >> k;
    assign diff  = z - p_r;
    assign q_ext = {2'b00, q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            out_t     <= '0;
            busy      <= 1'b0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            z         <= '0;
            p_r       <= '0;
            t         <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mul_a     <= in_a;
                        mul_b     <= in_b;
                        mul_start <= 1'b1;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= MUL_Z;
                    end
                end
                MUL_Z: begin
                    mul_start <= 1'b0;
                    state     <= WAIT_Z;
                end
                WAIT_Z: begin
                    if (mul_done) begin
                        z         <= mul_p;
                        mul_a     <= p_shr[W-1:0];
                        mul_b     <= mu;
                        mul_start <= 1'b1;
                        state     <= MUL_M2;
                    end
                end
                MUL_M2: begin
                    mul_start <= 1'b0;
                    state     <= WAIT_M2;
                end
                WAIT_M2: begin
                    if (mul_done) begin
                        mul_a     <= p_shr[W-1:0];
                        mul_b     <= q;
                        mul_start <= 1'b1;
                        state     <= MUL_P;
                    end
                end
                MUL_P: begin
                    mul_start <= 1'b0;
                    state     <= WAIT_P;
                end
                WAIT_P: begin
                    if (mul_done) begin
                        p_r   <= mul_p;
                        state <= SUB;
                    end
                end
                SUB: begin
                    t     <= diff[W+1:0];
                    cnt   <= '0;
                    state <= CORR;
                end
                CORR: begin
                    // A third pending correction means the inputs broke the a,b < q precondition.
                    if (t >= q_ext) begin
                        if (cnt == 2'(CORR_MAX)) begin
                            out_t     <= t[W-1:0];
                            out_err   <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            t   <= t - q_ext;
                            cnt <= cnt + 2'd1;
                        end
                    end else begin
                        out_t     <= t[W-1:0];
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_err   <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_barrett_modmul_ctrl.sv
// tb/tb_barrett_modmul_ctrl.sv - directed self-checking bench for barrett_modmul_ctrl
module tb_barrett_modmul_ctrl;

    localparam logic [63:0] Q61  = 64'h1FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MU61 = 64'h2000_0000_0000_0001;

    logic         clk;
    logic         rst;
    logic         cfg_we;
    logic [63:0]  cfg_q;
    logic [7:0]   cfg_k;
    logic [63:0]  cfg_mu;
    logic         cfg_err;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_a;
    logic [63:0]  in_b;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_t;
    logic         out_err;
    logic         busy;
    logic         mul_start;
    logic [63:0]  mul_a;
    logic [63:0]  mul_b;
    logic         mul_done;
    logic [127:0] mul_p;

    int errors;
    int checks;
    int lat;
    int start_cnt;

    barrett_modmul_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_q     (cfg_q),
        .cfg_k     (cfg_k),
        .cfg_mu    (cfg_mu),
        .cfg_err   (cfg_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_t     (out_t),
        .out_err   (out_err),
        .busy      (busy),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_done  (mul_done),
        .mul_p     (mul_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External multiplier: answers each launch lat cycles later with a one-cycle done.
    initial begin
        logic [127:0] pa;
        logic [127:0] pb;
        mul_done = 1'b0;
        mul_p    = '0;
        forever begin
            @(negedge clk);
            if (mul_start === 1'b1) begin
                pa = {64'd0, mul_a};
                pb = {64'd0, mul_b};
                repeat (lat) @(posedge clk);
                #1;
                mul_done = 1'b1;
                mul_p    = pa * pb;
                @(posedge clk);
                #1;
                mul_done = 1'b0;
            end
        end
    end

    always @(negedge clk) if (mul_start === 1'b1) start_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required end before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input logic [63:0] q, input logic [7:0] k, input logic [63:0] mu,
                             input logic exp_err);
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_q  = q;
        cfg_k  = k;
        cfg_mu = mu;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        @(negedge clk);
        check("cfg_err", cfg_err, exp_err);
    endtask

    // inject: 0 none, 1 config write during WAIT_M2 (L=4), 2 reset during WAIT_P (L=4)
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp_t,
                          input int exp_cyc, input logic exp_err, input int hold, input int inject);
        int   cyc;
        logic aborted;
        logic seen;
        @(negedge clk);
        check("in_ready_idle", in_ready, 1'b1);
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        start_cnt = 0;
        aborted   = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (inject == 1 && cyc == 8) begin
                cfg_we = 1'b1;
                cfg_q  = 64'd13;
                cfg_k  = 8'd4;
                cfg_mu = 64'd19;
                @(posedge clk);
                #1;
                cfg_we = 1'b0;
            end
            if (inject == 1 && cyc == 9) check("cfg_err_busy", cfg_err, 1'b1);
            if (inject == 2 && cyc == 13) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                aborted = 1'b1;
            end
        end while (!out_valid && cyc < 300 && !aborted);

        if (aborted) begin
            @(negedge clk);
            check("rst_in_ready", in_ready, 1'b1);
            check("rst_busy", busy, 1'b0);
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_out_t", out_t, 64'd0);
            check("rst_mul_start", mul_start, 1'b0);
            check("rst_mul_ab", {mul_a, mul_b}, 128'd0);
            seen = 1'b0;
            repeat (8) begin
                @(negedge clk);
                seen = seen | out_valid | busy;
            end
            check("rst_late_done_ignored", seen, 1'b0);
            return;
        end

        check("out_valid", out_valid, 1'b1);
        if (exp_cyc >= 0) check("latency", cyc, exp_cyc);
        check("out_t", out_t, exp_t);
        check("out_err", out_err, exp_err);
        check("busy_done", busy, 1'b1);
        check("mul_start_pulses", start_cnt, 3);

        if (hold > 0) begin
            in_a     = 64'd3;
            in_b     = 64'd4;
            in_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_in_ready", in_ready, 1'b0);
                check("hold_out_t", out_t, exp_t);
                check("hold_out_valid", out_valid, 1'b1);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("post_in_ready", in_ready, 1'b1);
        check("post_out_valid", out_valid, 1'b0);
        check("post_busy", busy, 1'b0);
        check("post_no_launch", mul_start, 1'b0);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        lat       = 1;
        start_cnt = 0;
        rst       = 1'b1;
        cfg_we    = 1'b0;
        cfg_q     = '0;
        cfg_k     = '0;
        cfg_mu    = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_err", out_err, 1'b0);
        check("reset_out_t", out_t, 64'd0);
        check("reset_busy", busy, 1'b0);
        check("reset_mul", {mul_start, mul_a, mul_b}, 129'd0);
        check("reset_cfg_err", cfg_err, 1'b0);

        cfg_write(64'd13, 8'd4, 64'd19, 1'b0);
        run_op(64'd7,   64'd9,   64'd11,   10, 1'b0, 5, 0);
        run_op(64'd12,  64'd12,  64'd1,    10, 1'b0, 0, 0);
        run_op(64'd0,   64'd9,   64'd0,     9, 1'b0, 0, 0);
        run_op(64'd255, 64'd255, 64'd2261, 11, 1'b1, 0, 0);

        cfg_write(64'd99, 8'd64, 64'd5, 1'b1);
        cfg_write(64'd99, 8'd0,  64'd5, 1'b1);
        run_op(64'd7, 64'd9, 64'd11, 10, 1'b0, 0, 0);

        lat = 4;
        cfg_write(Q61, 8'd61, MU61, 1'b0);
        run_op(Q61 - 64'd1, Q61 - 64'd1, 64'd1, 19, 1'b0, 0, 0);
        run_op(Q61 - 64'd1, Q61 - 64'd1, 64'd1, 19, 1'b0, 0, 1);
        run_op(Q61 - 64'd1, Q61 - 64'd1, 64'd1, 19, 1'b0, 0, 2);

        cfg_write(Q61, 8'd61, MU61, 1'b0);
        run_op(Q61 - 64'd1, Q61 - 64'd1, 64'd1, 19, 1'b0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
